// File: rtl/fifo_write_arbiter.sv
// Two-requester write arbiter in front of a FIFO. Grants are held for up to BURST
// words, alternate fairly when both sides are busy, and every accepted word is
// presented to the FIFO through a single output register.
module fifo_write_arbiter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             fifo_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_src,
  input  logic             stat_clear,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

  // Value of the burst counter when the final word of a grant is being accepted.
  localparam logic [3:0] BurstLast = 4'(BURST - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 0 = A served last, 1 = B served last
  logic [3:0]       burst_q, burst_d;
  logic             wr_en_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             wr_src_q;
  logic [7:0]       a_count_q, b_count_q;

  logic   acc_a, acc_b, acc;
  logic   in_grant_b, cur_valid, oth_valid, release_grant;
  state_e other_state;

  assign a_ready = (state_q == StGrantA) & fifo_ready;
  assign b_ready = (state_q == StGrantB) & fifo_ready;
  assign acc_a   = a_ready & a_valid;
  assign acc_b   = b_ready & b_valid;
  assign acc     = acc_a | acc_b;

  // Current/other requester as seen from whichever grant is active.
  assign in_grant_b    = (state_q == StGrantB);
  assign cur_valid     = in_grant_b ? b_valid : a_valid;
  assign oth_valid     = in_grant_b ? a_valid : b_valid;
  assign other_state   = in_grant_b ? StGrantA : StGrantB;
  assign release_grant = !cur_valid || (acc && (burst_q == BurstLast));

  // Next-state logic: grant selection, burst accounting and handover.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (a_valid && (!b_valid || last_q)) begin
          state_d = StGrantA;
          last_d  = 1'b0;
          burst_d = 4'd0;
        end else if (b_valid) begin
          state_d = StGrantB;
          last_d  = 1'b1;
          burst_d = 4'd0;
        end
      end
      StGrantA, StGrantB: begin
        if (release_grant) begin
          burst_d = 4'd0;
          if (oth_valid) begin
            state_d = other_state;
            last_d  = !in_grant_b;
          end else if (cur_valid) begin
            // Sole busy requester re-enters its own grant with a fresh burst.
            state_d = state_q;
            last_d  = in_grant_b;
          end else begin
            state_d = StIdle;
          end
        end else if (acc) begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // FIFO write register; a word accepted during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_src_q  <= 1'b0;
    end else begin
      wr_en_q <= acc;
      if (acc) begin
        wr_data_q <= acc_b ? b_data : a_data;
        wr_src_q  <= acc_b;
      end
    end
  end

  // Saturating per-requester word counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      a_count_q <= 8'd0;
      b_count_q <= 8'd0;
    end else begin
      if (acc_a && (a_count_q != 8'hFF)) a_count_q <= a_count_q + 8'd1;
      if (acc_b && (b_count_q != 8'hFF)) b_count_q <= b_count_q + 8'd1;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 6: data width of both requesters and the FIFO write port.
REQ-002 SHALL have parameter BURST, default 4, legal range 1..15: maximum words accepted per grant.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have ports a_valid / b_valid  input  1 each: requester A/B presents a word.
REQ-006 SHALL have ports a_data / b_data  input  WIDTH each: requester A/B word.
REQ-007 SHALL have ports a_ready / b_ready  output  1 each: word accepted this cycle when ready and valid are both high.
REQ-008 SHALL have port fifo_ready  input  1: high in cycle t guarantees the FIFO takes a write presented in cycle t+1.
REQ-009 SHALL have port wr_en  output  1: registered FIFO write strobe.
REQ-010 SHALL have port wr_data  output  WIDTH: registered FIFO write data.
REQ-011 SHALL have port wr_src  output  1: source of the current wr_data (0=A, 1=B).
REQ-012 SHALL have port stat_clear  input  1: synchronous clear of both word counters.
REQ-013 SHALL have ports a_count / b_count  output  8 each: words accepted from A/B.

Function
REQ-014 SHALL implement states IDLE, GRANT_A, GRANT_B, plus a 1-bit last-served pointer and a 4-bit burst counter.
REQ-015 SHALL drive a_ready = (state==GRANT_A) & fifo_ready and b_ready = (state==GRANT_B) & fifo_ready, combinationally.
REQ-016 SHALL, in IDLE: with only one valid, enter that requester's grant; with both valid, grant the requester other than last-served; with neither, stay in IDLE.
REQ-017 SHALL, on entering any grant, clear the burst counter and set last-served to the granted requester.
REQ-018 SHALL increment the burst counter on each accepted word.
REQ-019 SHALL release a grant in the cycle its requester's valid is low, or in the cycle the BURST-th word of the grant is accepted.
REQ-020 SHALL, on release, enter the other requester's grant if it is valid; otherwise re-enter the same grant (counter cleared) if the released requester is valid; otherwise go to IDLE.
REQ-021 SHALL, when a word is accepted in cycle t, assert wr_en in cycle t+1 with wr_data and wr_src of that word: 1-cycle latency, no internal buffering beyond that register.
REQ-022 SHALL deassert wr_en in any cycle following a cycle with no acceptance; wr_data and wr_src hold their last values.
REQ-023 SHALL hold the grant with counter unchanged while fifo_ready is low; a stalled grant is released only by valid dropping.
REQ-024 SHALL increment a_count/b_count per accepted word, saturating at 255 (no wrap).
REQ-025 SHALL give stat_clear priority over a same-cycle increment: counters read 0 next cycle.
REQ-026 SHALL never assert a_ready and b_ready in the same cycle.

Reset
REQ-027 SHALL, in any cycle with reset high, regardless of state, set next state to IDLE, last-served to B (A preferred first), burst counter 0, wr_en 0, wr_data 0, wr_src 0, a_count 0, b_count 0.
REQ-028 SHALL hold a_ready = b_ready = 0 while in IDLE after reset, so a word offered during reset or in the first post-reset cycle is not accepted until a grant is entered.
REQ-029 SHALL discard any word accepted in the cycle reset is asserted: no wr_en follows it.

Verification
REQ-030 SHALL cover: reset, then a_valid=1 with data 0x15, fifo_ready=1 -> GRANT_A next cycle, a_ready=1, wr_en=1, wr_data=0x15, wr_src=0 one cycle after acceptance.
REQ-031 SHALL cover: both valid continuously, fifo_ready=1, BURST=4 -> acceptance pattern A,A,A,A,B,B,B,B,A,...; no idle cycle at handover; counts 4/4 after 8 words.
REQ-032 SHALL cover: only A valid for 10 words -> uninterrupted acceptance; after BURST expiry the grant re-enters A; a_count=10.
REQ-033 SHALL cover: fifo_ready low for 3 cycles mid-burst -> a_ready=0, wr_en=0 the following cycles, burst counter unchanged; burst completes after fifo_ready returns.
REQ-034 SHALL cover: 300 A words -> a_count saturates at 255; stat_clear with a concurrent acceptance -> a_count=0.
REQ-035 SHALL cover: reset asserted in GRANT_B mid-burst with an acceptance that cycle -> no wr_en next cycle, IDLE, counters 0; with both valid afterwards, A is granted first.
